// File: rtl/z80_int_pkg.sv
// Shared definitions for the Z80 interrupt controller.
//   state_e    : controller FSM states
//   VEC_W      : width of the IM2 vector driven on the data bus
//   ACK_DECODE : {/M1, /IORQ} pattern that marks an interrupt-acknowledge cycle
//   is_ack()   : decodes an acknowledge cycle from the two Z80 strobes
package z80_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam int VEC_W = 8;

    // Both /M1 and /IORQ low together only happens on interrupt acknowledge.
    localparam logic [1:0] ACK_DECODE = 2'b00;

    function automatic logic is_ack(input logic m1_n, input logic iorq_n);
        return ({m1_n, iorq_n} == ACK_DECODE);
    endfunction

endpackage

// File: rtl/z80_int_ctrl_int_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   idx   : index of the lowest set bit (0 when nothing is set)
//   valid : 1 when any request bit is set
module int_prio_enc #(
    parameter int NSRC  = 4,
    parameter int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan upward and keep the first hit so bit 0 always wins.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (req[i] && !valid) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller.
// Latches per-source strobes into pending bits, masks them, drives /INT,
// and answers the acknowledge cycle with a vector for the highest-priority
// enabled source, clearing that source's pending bit.
//   clk_z80, rst_n         : clock (rising edge) and async active-low reset
//   int_stb                : one-cycle request strobes, one per source
//   mask_we / mask_wdata   : enable-mask write (1 = enabled)
//   clr_we / clr_wdata     : write-one-to-clear of pending bits
//   z_m1_n / z_iorq_n      : Z80 bus strobes, already in the clk_z80 domain
//   z_int_n                : registered /INT, low only while requesting
//   int_vector / _oe       : registered IM2 vector and its bus drive enable
//   mask / pending         : register readback
module z80_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int                NSRC     = 4,
    parameter logic [VEC_W-1:0]  VEC_BASE = 8'hF0,
    parameter logic [NSRC-1:0]   MASK_RST = {NSRC{1'b0}},
    parameter int                RECOV    = 2
) (
    input  logic             clk_z80,
    input  logic             rst_n,
    input  logic [NSRC-1:0]  int_stb,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    input  logic             clr_we,
    input  logic [NSRC-1:0]  clr_wdata,
    input  logic             z_m1_n,
    input  logic             z_iorq_n,
    output logic             z_int_n,
    output logic [VEC_W-1:0] int_vector,
    output logic             int_vector_oe,
    output logic [NSRC-1:0]  mask,
    output logic [NSRC-1:0]  pending
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CNT_W = (RECOV > 1) ? $clog2(RECOV) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NSRC-1:0]    pending_q, pending_d;
    logic [NSRC-1:0]    mask_q, mask_d;
    logic               ack_q;
    logic               z_int_n_q, z_int_n_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               oe_q, oe_d;

    logic               ack_s;
    logic               ack_rise_s;
    logic               req_s;
    logic               take_s;
    logic [IDX_W-1:0]   sel_s;
    logic [NSRC-1:0]    clr_s;

    assign ack_s      = is_ack(z_m1_n, z_iorq_n);
    assign ack_rise_s = ack_s & ~ack_q;

    // Encoder output valid is exactly |(pending & mask), so it doubles as req.
    int_prio_enc #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (pending_q & mask_q),
        .idx   (sel_s),
        .valid (req_s)
    );

    // FSM next state, vector capture and recovery countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        oe_d    = 1'b0;
        take_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An acknowledge seen here is not ours; stay off the bus.
                if (req_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else if (ack_rise_s) begin
                    take_s  = 1'b1;
                    vec_d   = VEC_BASE | (VEC_W'(sel_s) << 1);
                    oe_d    = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACK: begin
                if (ack_s) begin
                    oe_d    = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(RECOV - 1);
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        z_int_n_d = (state_d != ST_REQ);
    end

    // Pending and mask update; a new strobe beats any clear in the same cycle.
    always_comb begin
        clr_s = {NSRC{1'b0}};
        if (clr_we) begin
            clr_s = clr_wdata;
        end else begin
            clr_s = {NSRC{1'b0}};
        end
        if (take_s) begin
            clr_s = clr_s | (NSRC'(1) << sel_s);
        end else begin
            clr_s = clr_s;
        end
        pending_d = (pending_q & ~clr_s) | int_stb;
        if (mask_we) begin
            mask_d = mask_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_z80 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            pending_q <= {NSRC{1'b0}};
            mask_q    <= MASK_RST;
            ack_q     <= 1'b0;
            z_int_n_q <= 1'b1;
            vec_q     <= VEC_BASE;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ack_q     <= ack_s;
            z_int_n_q <= z_int_n_d;
            vec_q     <= vec_d;
            oe_q      <= oe_d;
        end
    end

    assign z_int_n       = z_int_n_q;
    assign int_vector    = vec_q;
    assign int_vector_oe = oe_q;
    assign mask          = mask_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed, table-driven bench for z80_int_ctrl (NSRC=4, VEC_BASE=F0, RECOV=2).
// Each table row gives the inputs held for one clock and the outputs expected
// just after that edge.
module tb_z80_int_ctrl;

    logic       clk_z80 = 1'b0;
    logic       rst_n;
    logic [3:0] int_stb;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       clr_we;
    logic [3:0] clr_wdata;
    logic       z_m1_n;
    logic       z_iorq_n;
    logic       z_int_n;
    logic [7:0] int_vector;
    logic       int_vector_oe;
    logic [3:0] mask;
    logic [3:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_z80 = ~clk_z80;

    z80_int_ctrl #(
        .NSRC     (4),
        .VEC_BASE (8'hF0),
        .MASK_RST (4'b0000),
        .RECOV    (2)
    ) dut (
        .clk_z80       (clk_z80),
        .rst_n         (rst_n),
        .int_stb       (int_stb),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .clr_we        (clr_we),
        .clr_wdata     (clr_wdata),
        .z_m1_n        (z_m1_n),
        .z_iorq_n      (z_iorq_n),
        .z_int_n       (z_int_n),
        .int_vector    (int_vector),
        .int_vector_oe (int_vector_oe),
        .mask          (mask),
        .pending       (pending)
    );

    typedef struct {
        logic [3:0] stb;
        logic       mwe;
        logic [3:0] mwd;
        logic       cwe;
        logic [3:0] cwd;
        logic       ack;
        logic       e_int_n;
        logic [7:0] e_vec;
        logic       e_oe;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] stb, input logic mwe, input logic [3:0] mwd,
                                input logic cwe, input logic [3:0] cwd, input logic ack,
                                input logic e_int_n, input logic [7:0] e_vec, input logic e_oe,
                                input logic [3:0] e_pend, input logic [3:0] e_mask);
        vec_t v;
        v.stb = stb; v.mwe = mwe; v.mwd = mwd; v.cwe = cwe; v.cwd = cwd; v.ack = ack;
        v.e_int_n = e_int_n; v.e_vec = e_vec; v.e_oe = e_oe; v.e_pend = e_pend; v.e_mask = e_mask;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_int_n, input logic [7:0] e_vec,
                             input logic e_oe, input logic [3:0] e_pend, input logic [3:0] e_mask);
        check("z_int_n", idx, 32'(z_int_n), 32'(e_int_n));
        check("int_vector", idx, 32'(int_vector), 32'(e_vec));
        check("int_vector_oe", idx, 32'(int_vector_oe), 32'(e_oe));
        check("pending", idx, 32'(pending), 32'(e_pend));
        check("mask", idx, 32'(mask), 32'(e_mask));
    endtask

    task automatic idle_inputs();
        int_stb = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
        clr_we = 1'b0; clr_wdata = 4'b0000; z_m1_n = 1'b1; z_iorq_n = 1'b1;
    endtask

    initial begin
        // stb, mwe, mwd, cwe, cwd, ack | int_n, vec, oe, pend, mask
        // Single source 0: request, acknowledge, recovery.
        tbl.push_back(mk(4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h1)); // 0
        tbl.push_back(mk(4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h1, 4'h1)); // 1
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF0, 1'b0, 4'h1, 4'h1)); // 2
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h0, 4'h1)); // 3
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h0, 4'h1)); // 4
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h1)); // 5
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h1)); // 6
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h1)); // 7
        // Two sources together: priority order F2 then F4.
        tbl.push_back(mk(4'h0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h0, 4'hF)); // 8
        tbl.push_back(mk(4'h6, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h6, 4'hF)); // 9
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF0, 1'b0, 4'h6, 4'hF)); // 10
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF2, 1'b1, 4'h4, 4'hF)); // 11
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF2, 1'b0, 4'h4, 4'hF)); // 12
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF2, 1'b0, 4'h4, 4'hF)); // 13
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF2, 1'b0, 4'h4, 4'hF)); // 14
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF2, 1'b0, 4'h4, 4'hF)); // 15
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF4, 1'b1, 4'h0, 4'hF)); // 16
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'hF)); // 17
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'hF)); // 18
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'hF)); // 19
        // Masked pending, then enabled by a mask write; then withdrawn by clear.
        tbl.push_back(mk(4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h0)); // 20
        tbl.push_back(mk(4'h4, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h4, 4'h0)); // 21
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h4, 4'h0)); // 22
        tbl.push_back(mk(4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h4, 4'h4)); // 23
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF4, 1'b0, 4'h4, 4'h4)); // 24
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0, 8'hF4, 1'b0, 4'h0, 4'h4)); // 25
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h4)); // 26
        // Source 0 cleared before ack; the later ack is ignored in IDLE.
        tbl.push_back(mk(4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h1)); // 27
        tbl.push_back(mk(4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h1, 4'h1)); // 28
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF4, 1'b0, 4'h1, 4'h1)); // 29
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 8'hF4, 1'b0, 4'h0, 4'h1)); // 30
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h1)); // 31
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h1)); // 32
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h0, 4'h1)); // 33
        // Strobe beats clear; strobe during ACK re-arms and is serviced again.
        tbl.push_back(mk(4'h1, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 8'hF4, 1'b0, 4'h1, 4'h1)); // 34
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF4, 1'b0, 4'h1, 4'h1)); // 35
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h0, 4'h1)); // 36
        tbl.push_back(mk(4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h1, 4'h1)); // 37
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h1, 4'h1)); // 38
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h1, 4'h1)); // 39
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hF0, 1'b0, 4'h1, 4'h1)); // 40
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'hF0, 1'b0, 4'h1, 4'h1)); // 41
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h0, 4'h1)); // 42
        // Mask write during ACK does not abort the acknowledge.
        tbl.push_back(mk(4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hF0, 1'b1, 4'h0, 4'h0)); // 43

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_all(-1, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h0);
        @(negedge clk_z80);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            int_stb    = tbl[i].stb;
            mask_we    = tbl[i].mwe;
            mask_wdata = tbl[i].mwd;
            clr_we     = tbl[i].cwe;
            clr_wdata  = tbl[i].cwd;
            z_m1_n     = ~tbl[i].ack;
            z_iorq_n   = ~tbl[i].ack;
            @(posedge clk_z80);
            #1;
            check_all(i, tbl[i].e_int_n, tbl[i].e_vec, tbl[i].e_oe, tbl[i].e_pend, tbl[i].e_mask);
        end

        // Still in ACK with ack held: pull reset mid-cycle, away from any edge.
        mask_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(100, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h0);

        // Release reset with the bus idle; controller must sit quietly.
        idle_inputs();
        @(negedge clk_z80);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_z80);
            #1;
            check_all(101 + k, 1'b1, 8'hF0, 1'b0, 4'h0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
